// File: rtl/shift_pkg.sv
// shift_pkg: shared shift-register mode codes and serializer FSM states.
//   MODE_* : 2-bit mode encoding understood by shift_reg
//   state_t: shift_tx_ctrl sequencer states
package shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

endpackage

// File: rtl/shift_reg.sv
// shift_reg: universal shift register (hold / shift right / shift left / load).
//   clk, rst   : clock, asynchronous active-high reset (clears out)
//   mode       : MODE_HOLD, MODE_SHR (LSB leaves), MODE_SHL (MSB leaves), MODE_LOAD
//   p_in       : parallel load word
//   s_in       : serial fill bit entering the vacated end
//   out        : register contents
module shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in,
    output logic [WIDTH-1:0] out
);

    always_ff @(posedge clk or posedge rst)
        if (rst)
            out <= '0;
        else
            out <= mode == MODE_LOAD ? p_in :
                   mode == MODE_SHR  ? {s_in, out[WIDTH-1:1]} :
                   mode == MODE_SHL  ? {out[WIDTH-2:0], s_in} : out;

endmodule

// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: sequences a shift_reg as a flow-controlled word serializer.
//   clk, rst             : clock, asynchronous active-high reset
//   in_data, lsb_first   : word and bit order, taken when in_valid && in_ready
//   in_valid, in_ready   : upstream word handshake
//   sr_mode, sr_p_in,
//   sr_s_in, sr_q        : control/data to and from the shift_reg
//   ser_data, ser_valid,
//   ser_last, ser_ready  : downstream serial bit handshake
module shift_tx_ctrl
    import shift_pkg::*;
#(
    parameter int   WIDTH = 8,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             lsb_first,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_p_in,
    output logic             sr_s_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic             ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready
);

    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;

    state_t        state;
    logic          dir_lsb;
    logic [CW-1:0] bit_cnt;

    assign sr_s_in   = FILL;
    assign ser_valid = state == SHIFT;
    assign ser_last  = ser_valid && bit_cnt == CW'(WIDTH - 1);
    // The outgoing bit is always at the end the register shifts away from.
    assign ser_data  = dir_lsb ? sr_q[0] : sr_q[WIDTH-1];
    assign in_ready  = state == IDLE || (ser_last && ser_ready);

    always_comb
        sr_mode = state == LOAD ? MODE_LOAD :
                  ser_valid && ser_ready ? (dir_lsb ? MODE_SHR : MODE_SHL) : MODE_HOLD;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            sr_p_in <= '0;
            dir_lsb <= 1'b0;
        end else if (state == LOAD) begin
            state   <= SHIFT;
            bit_cnt <= '0;
        end else if (state == SHIFT && ser_ready && !ser_last) begin
            bit_cnt <= bit_cnt + CW'(1);
        end else if (in_ready) begin
            // Covers IDLE and the last-bit edge of SHIFT: chain straight into LOAD.
            if (in_valid) begin
                sr_p_in <= in_data;
                dir_lsb <= lsb_first;
            end
            state <= in_valid ? LOAD : IDLE;
        end

endmodule

// File: doc/shift_tx_ctrl.md
# shift_tx_ctrl

Sequencer that sits directly upstream of the universal shift register `shift_reg` and turns it into a word serializer. It accepts parallel words over a valid/ready handshake, issues one parallel-load cycle, then drives exactly WIDTH shift cycles in the selected direction. It presents each serial bit to a downstream consumer with its own valid/ready backpressure, converting the shift register into a flow-controlled parallel-to-serial transmitter.

## Interface
- `WIDTH`, default 8: word width; must match the driven `shift_reg`.
- `FILL`, default 1'b0: bit driven on `sr_s_in` during shifts.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  word to transmit.
- `lsb_first`  in  1  direction, sampled with `in_data` at accept.
- `in_valid`  in  1  `in_data` and `lsb_first` are valid.
- `in_ready`  out  1  controller can accept a word this cycle.
- `sr_mode`  out  2  to `shift_reg.mode`: 00 hold, 01 shift right (LSB leaves), 10 shift left (MSB leaves), 11 parallel load.
- `sr_p_in`  out  WIDTH  to `shift_reg.p_in`.
- `sr_s_in`  out  1  to `shift_reg.s_in`; constant `FILL`.
- `sr_q`  in  WIDTH  from `shift_reg.out`.
- `ser_data`  out  1  current serial bit.
- `ser_valid`  out  1  `ser_data` is valid.
- `ser_last`  out  1  current bit is the final bit of the word.
- `ser_ready`  in  1  downstream consumes the bit on this rising edge.

## Operation
- FSM states: IDLE, LOAD, SHIFT. `state`, `dir_lsb`, `sr_p_in` and `bit_cnt` (width `$clog2(WIDTH)`) are registered.
- IDLE: `in_ready`=1 and `sr_mode`=00. If `in_valid`, then at the edge: `sr_p_in`<=`in_data`, `dir_lsb`<=`lsb_first`, and the FSM moves to LOAD.
- LOAD, exactly one cycle: `sr_mode`=11, `in_ready`=0, `ser_valid`=0. `shift_reg` captures `sr_p_in` at the closing edge. The FSM then moves to SHIFT with `bit_cnt`<=0.
- SHIFT:
  - `ser_valid`=1.
  - `ser_data` = `sr_q[0]` when `dir_lsb`, otherwise `sr_q[WIDTH-1]`.
  - `ser_last` = (`bit_cnt`==WIDTH-1).
  - `sr_mode` is combinational: `ser_ready` ? (`dir_lsb` ? 01 : 10) : 00.
  - When `ser_ready`=1 and the bit is not the last: `bit_cnt`++.
  - When `ser_ready`=1 and the bit is the last: `in_ready`=1. If `in_valid` is also 1, capture the new word and go to LOAD; otherwise go to IDLE.
  - When `ser_ready`=0: hold everything; `ser_data`, `ser_last` and `bit_cnt` stay stable.
- `in_ready` is combinational: (IDLE) or (SHIFT and `ser_last` and `ser_ready`). It never depends on `in_valid`.
- `bit_cnt` never exceeds WIDTH-1; no wrap-around is possible.

## Timing
- Reset, effective immediately and asynchronously:
  - state=IDLE, `bit_cnt`=0, `sr_p_in`=0, `dir_lsb`=0.
  - Resulting outputs: `sr_mode`=00, `ser_valid`=0, `ser_last`=0, `in_ready`=1 (once `rst` deasserts), `ser_data` follows `sr_q[WIDTH-1]`.
- Reset mid-word drops the word. No partial bits are emitted after `rst` rises.
- Timeline for a word accepted at edge k, with no stall:
  - LOAD during cycle k→k+1.
  - Bit i valid during cycle k+1+i, for i=0..WIDTH-1.
- Throughput is WIDTH+1 cycles per word under continuous `in_valid`. The single LOAD cycle is the only gap.
- Each stall cycle adds one cycle and never loses or duplicates a bit.
- `sr_s_in`=`FILL` in every state; the vacated bits are don't-care.

## Structure
- Shared package `shift_pkg`:
  - mode constants `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11, also used by `shift_reg` and its bench;
  - the FSM state enum.
- No sub-module inside `shift_tx_ctrl`.
- Top-level pairing: `shift_tx_ctrl` + one `shift_reg #(WIDTH)`, wired `sr_*` ↔ `mode`/`p_in`/`s_in`/`out`.
- The bench instantiates this pair.

## Test plan
- Reset: hold `rst` for 2 cycles with `in_valid`=1 → `sr_mode`=00, `ser_valid`=0, `in_ready`=1 after release, and no word is accepted during reset.
- LSB-first: word 8'b10101010, `lsb_first`=1, `ser_ready`=1 → `sr_mode` is 11 for 1 cycle, then 01 for 8 cycles; `ser_data` is 0,1,0,1,0,1,0,1; `ser_last` only on the 8th bit; then IDLE.
- MSB-first: word 8'hC3, `lsb_first`=0 → `sr_mode` is 10 for 8 cycles; bits are 1,1,0,0,0,0,1,1.
- Stall: drop `ser_ready` for 3 cycles while bit 3 is presented → `sr_mode`=00 and `ser_data`/`bit_cnt` are frozen in those cycles; total SHIFT duration is 11 cycles; the bit sequence is unchanged.
- Back-to-back: words 8'hA5 then 8'h3C with `in_valid` held → second word accepted on the last-bit edge of the first; exactly one LOAD cycle between word streams; 9-cycle period; both words correct.
- Reset mid-word: assert `rst` while bit 4 is presented → `ser_valid` falls immediately and `sr_mode`=00; the next word 8'hFF transmits 8 ones cleanly.
